// File: rtl/rv64_pkg.sv
// Shared definitions for the integer register file scoreboard.
// Optional feature macro used by the scoreboard: SCOREBOARD_WB_BYPASS_EN.
package rv64_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NREG      = 32;
  localparam int CNT_W     = 2;
  localparam int PERF_W    = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]     sb_cnt_t;

  // Largest number of writes that may be in flight for one destination.
  localparam sb_cnt_t CNT_MAX = '1;

  // x0 is hardwired to zero, so it never takes part in tracking.
  function automatic logic idx_tracked(input reg_idx_t idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/sb_counter_bank.sv
// Bank of per-register pending-write counters: one increment port, one
// decrement port, synchronous flush. Counters neither wrap up nor down.
module sb_counter_bank
  import rv64_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     inc_en,
  input  reg_idx_t inc_idx,
  input  logic     dec_en,
  input  reg_idx_t dec_idx,
  output sb_cnt_t  cnt [NREG]
);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_cnt
      if (gi == 0) begin : g_x0
        // x0 never holds a pending write.
        assign cnt[gi] = '0;
      end else begin : g_reg
        logic    inc_hit;
        logic    dec_hit;
        sb_cnt_t cnt_reg;
        sb_cnt_t cnt_next;

        assign inc_hit = inc_en && (inc_idx == reg_idx_t'(gi));
        assign dec_hit = dec_en && (dec_idx == reg_idx_t'(gi));

        // Next count: flush wins; a matching inc and dec cancel out.
        always_comb begin
          cnt_next = cnt_reg;
          if (flush) begin
            cnt_next = '0;
          end else if (inc_hit && !dec_hit && cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + sb_cnt_t'(1);
          end else if (dec_hit && !inc_hit && cnt_reg != '0) begin
            cnt_next = cnt_reg - sb_cnt_t'(1);
          end
        end

        // Counter state register.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) cnt_reg <= '0;
          else        cnt_reg <= cnt_next;
        end

        assign cnt[gi] = cnt_reg;
      end
    end
  endgenerate

endmodule

// File: rtl/regfile_scoreboard.sv
// RAW interlock scoreboard between decode and issue. Counts in-flight
// writes per destination register and holds decode while a source is busy.
// Optional macro SCOREBOARD_WB_BYPASS_EN: a retirement that clears the last
// pending write to a source removes the stall in the same cycle and asks
// decode to forward the writeback data.
module regfile_scoreboard
  import rv64_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              decode_i_valid,
  input  reg_idx_t          decode_i_rs1,
  input  logic              decode_i_rs1_ren,
  input  reg_idx_t          decode_i_rs2,
  input  logic              decode_i_rs2_ren,
  input  reg_idx_t          decode_i_rd,
  input  logic              decode_i_reg_wen,
  output logic              decode_o_ready,
  input  logic              write_back_i_valid,
  input  reg_idx_t          write_back_i_rd,
  input  logic              write_back_i_reg_wen,
  input  logic              flush_i,
  output logic              decode_o_fwd_rs1,
  output logic              decode_o_fwd_rs2,
  output logic [PERF_W-1:0] sb_o_stall_cnt,
  output logic              sb_o_err
);

  sb_cnt_t           cnt [NREG];
  sb_cnt_t           cnt_rs1;
  sb_cnt_t           cnt_rs2;
  sb_cnt_t           cnt_rd;
  sb_cnt_t           cnt_wb;
  logic              hazard_rs1;
  logic              hazard_rs2;
  logic              sat;
  logic              issue;
  logic              retire;
  logic [PERF_W-1:0] stall_cnt_reg;
  logic              err_reg;

  assign cnt_rs1 = cnt[decode_i_rs1];
  assign cnt_rs2 = cnt[decode_i_rs2];
  assign cnt_rd  = cnt[decode_i_rd];
  assign cnt_wb  = cnt[write_back_i_rd];

  assign retire = write_back_i_valid && write_back_i_reg_wen && idx_tracked(write_back_i_rd);
  assign issue  = decode_i_valid && decode_o_ready && decode_i_reg_wen && idx_tracked(decode_i_rd);

  // Hazard, saturation, forwarding and ready from current counters.
  always_comb begin
    decode_o_fwd_rs1 = 1'b0;
    decode_o_fwd_rs2 = 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
    decode_o_fwd_rs1 = retire && decode_i_rs1_ren && (write_back_i_rd == decode_i_rs1)
                       && (cnt_rs1 == sb_cnt_t'(1));
    decode_o_fwd_rs2 = retire && decode_i_rs2_ren && (write_back_i_rd == decode_i_rs2)
                       && (cnt_rs2 == sb_cnt_t'(1));
`endif
    hazard_rs1 = decode_i_rs1_ren && idx_tracked(decode_i_rs1) && (cnt_rs1 != '0)
                 && !decode_o_fwd_rs1;
    hazard_rs2 = decode_i_rs2_ren && idx_tracked(decode_i_rs2) && (cnt_rs2 != '0)
                 && !decode_o_fwd_rs2;
    sat        = decode_i_reg_wen && idx_tracked(decode_i_rd) && (cnt_rd == CNT_MAX);
    decode_o_ready = !(hazard_rs1 || hazard_rs2 || sat);
  end

  sb_counter_bank u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush_i),
    .inc_en  (issue),
    .inc_idx (decode_i_rd),
    .dec_en  (retire),
    .dec_idx (write_back_i_rd)
  , .cnt     (cnt)
  );

  // Stall-cycle performance counter; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               stall_cnt_reg <= '0;
    else if (decode_i_valid && !decode_o_ready) stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  // Sticky flag: a retirement arrived for a register with nothing pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       err_reg <= 1'b0;
    else if (retire && cnt_wb == '0)  err_reg <= 1'b1;
  end

  assign sb_o_stall_cnt = stall_cnt_reg;
  assign sb_o_err       = err_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed testbench for regfile_scoreboard. Builds with or without
// SCOREBOARD_WB_BYPASS_EN and adjusts the expected bypass behaviour.
module tb_regfile_scoreboard;
  import rv64_pkg::*;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              decode_i_valid;
  reg_idx_t          decode_i_rs1;
  logic              decode_i_rs1_ren;
  reg_idx_t          decode_i_rs2;
  logic              decode_i_rs2_ren;
  reg_idx_t          decode_i_rd;
  logic              decode_i_reg_wen;
  logic              decode_o_ready;
  logic              write_back_i_valid;
  reg_idx_t          write_back_i_rd;
  logic              write_back_i_reg_wen;
  logic              flush_i;
  logic              decode_o_fwd_rs1;
  logic              decode_o_fwd_rs2;
  logic [PERF_W-1:0] sb_o_stall_cnt;
  logic              sb_o_err;

  int checks = 0;
  int errors = 0;
  int stall_exp = 0;

  regfile_scoreboard dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .decode_i_valid       (decode_i_valid),
    .decode_i_rs1         (decode_i_rs1),
    .decode_i_rs1_ren     (decode_i_rs1_ren),
    .decode_i_rs2         (decode_i_rs2),
    .decode_i_rs2_ren     (decode_i_rs2_ren),
    .decode_i_rd          (decode_i_rd),
    .decode_i_reg_wen     (decode_i_reg_wen),
    .decode_o_ready       (decode_o_ready),
    .write_back_i_valid   (write_back_i_valid),
    .write_back_i_rd      (write_back_i_rd),
    .write_back_i_reg_wen (write_back_i_reg_wen),
    .flush_i              (flush_i),
    .decode_o_fwd_rs1     (decode_o_fwd_rs1),
    .decode_o_fwd_rs2     (decode_o_fwd_rs2),
    .sb_o_stall_cnt       (sb_o_stall_cnt),
    .sb_o_err             (sb_o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    decode_i_valid       = 1'b0;
    decode_i_rs1         = '0;
    decode_i_rs1_ren     = 1'b0;
    decode_i_rs2         = '0;
    decode_i_rs2_ren     = 1'b0;
    decode_i_rd          = '0;
    decode_i_reg_wen     = 1'b0;
    write_back_i_valid   = 1'b0;
    write_back_i_rd      = '0;
    write_back_i_reg_wen = 1'b0;
    flush_i              = 1'b0;
  endtask

  task automatic dec(input logic v, input int rs1, input logic r1, input int rs2,
                     input logic r2, input int rd, input logic wen);
    decode_i_valid   = v;
    decode_i_rs1     = reg_idx_t'(rs1);
    decode_i_rs1_ren = r1;
    decode_i_rs2     = reg_idx_t'(rs2);
    decode_i_rs2_ren = r2;
    decode_i_rd      = reg_idx_t'(rd);
    decode_i_reg_wen = wen;
  endtask

  task automatic wb(input logic v, input int rd);
    write_back_i_valid   = v;
    write_back_i_rd      = reg_idx_t'(rd);
    write_back_i_reg_wen = v;
  endtask

  // Check the combinational outputs for the inputs now driven, then advance one clock.
  task automatic cycle(input string tag, input logic exp_ready, input logic exp_f1,
                       input logic exp_f2);
    #1;
    check({tag, ".rdy"}, 32'(decode_o_ready), 32'(exp_ready));
    check({tag, ".f1"}, 32'(decode_o_fwd_rs1), 32'(exp_f1));
    check({tag, ".f2"}, 32'(decode_o_fwd_rs2), 32'(exp_f2));
    if (decode_i_valid && !exp_ready) stall_exp++;
    @(posedge clk);
    #2;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #3;
    check("rst.stall", sb_o_stall_cnt, 32'd0);
    check("rst.err", 32'(sb_o_err), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Reset state: a read of x5 is free.
    dec(1, 5, 1, 0, 0, 0, 0);
    cycle("rst.rd5", 1'b1, 1'b0, 1'b0);
    check("rst.stall2", sb_o_stall_cnt, 32'd0);

    // RAW stall on x5.
    dec(1, 0, 0, 0, 0, 5, 1);
    cycle("raw.iss5", 1'b1, 1'b0, 1'b0);
    dec(1, 5, 1, 0, 0, 0, 0);
    cycle("raw.stall1", 1'b0, 1'b0, 1'b0);
    check("raw.scnt1", sb_o_stall_cnt, 32'd1);
    wb(1, 5);
    cycle("raw.retire", BYP, BYP, 1'b0);
    wb(0, 0);
    cycle("raw.after", 1'b1, 1'b0, 1'b0);
    check("raw.scnt2", sb_o_stall_cnt, BYP ? 32'd1 : 32'd2);

    // Saturation of x7 at three pending writes.
    dec(1, 0, 0, 0, 0, 7, 1);
    cycle("sat.iss1", 1'b1, 1'b0, 1'b0);
    cycle("sat.iss2", 1'b1, 1'b0, 1'b0);
    cycle("sat.iss3", 1'b1, 1'b0, 1'b0);
    cycle("sat.full", 1'b0, 1'b0, 1'b0);
    wb(1, 7);
    cycle("sat.retire", 1'b0, 1'b0, 1'b0);
    wb(0, 0);
    cycle("sat.iss4", 1'b1, 1'b0, 1'b0);
    cycle("sat.full2", 1'b0, 1'b0, 1'b0);
    dec(0, 0, 0, 0, 0, 0, 0);
    wb(1, 7);
    cycle("sat.drain1", 1'b1, 1'b0, 1'b0);
    cycle("sat.drain2", 1'b1, 1'b0, 1'b0);
    cycle("sat.drain3", 1'b1, 1'b0, 1'b0);
    wb(0, 0);
    dec(1, 7, 1, 0, 0, 0, 0);
    cycle("sat.empty", 1'b1, 1'b0, 1'b0);

    // Issue and retire of x9 in one cycle keeps its count at 1.
    dec(1, 0, 0, 0, 0, 9, 1);
    cycle("same.iss", 1'b1, 1'b0, 1'b0);
    wb(1, 9);
    cycle("same.both", 1'b1, 1'b0, 1'b0);
    wb(0, 0);
    dec(1, 9, 1, 0, 0, 0, 0);
    cycle("same.rs1", 1'b0, 1'b0, 1'b0);
    dec(1, 0, 0, 9, 1, 0, 0);
    cycle("same.rs2", 1'b0, 1'b0, 1'b0);

    // Flush with x3 pending twice and a concurrent issue to x3.
    dec(1, 0, 0, 0, 0, 3, 1);
    cycle("fl.iss1", 1'b1, 1'b0, 1'b0);
    cycle("fl.iss2", 1'b1, 1'b0, 1'b0);
    dec(1, 3, 1, 0, 0, 0, 0);
    cycle("fl.busy", 1'b0, 1'b0, 1'b0);
    dec(1, 0, 0, 0, 0, 3, 1);
    flush_i = 1'b1;
    cycle("fl.flush", 1'b1, 1'b0, 1'b0);
    flush_i = 1'b0;
    dec(1, 3, 1, 9, 1, 0, 0);
    cycle("fl.clear", 1'b1, 1'b0, 1'b0);

    // x0 issue and retire are ignored.
    dec(1, 0, 1, 0, 1, 0, 1);
    wb(1, 0);
    cycle("x0.iss", 1'b1, 1'b0, 1'b0);
    wb(0, 0);
    cycle("x0.read", 1'b1, 1'b0, 1'b0);
    check("x0.err", 32'(sb_o_err), 32'd0);

    // Spurious retire of x12.
    dec(0, 0, 0, 0, 0, 0, 0);
    wb(1, 12);
    cycle("err.wb12", 1'b1, 1'b0, 1'b0);
    check("err.set", 32'(sb_o_err), 32'd1);
    wb(0, 0);
    dec(1, 12, 1, 0, 0, 0, 0);
    cycle("err.rd12", 1'b1, 1'b0, 1'b0);
    cycle("err.idle", 1'b1, 1'b0, 1'b0);
    check("err.sticky", 32'(sb_o_err), 32'd1);
    check("end.stall", sb_o_stall_cnt, 32'(stall_exp));

    // Asynchronous reset in mid-cycle, with x5 pending.
    dec(1, 0, 0, 0, 0, 5, 1);
    cycle("ar.iss5", 1'b1, 1'b0, 1'b0);
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    check("ar.err", 32'(sb_o_err), 32'd0);
    check("ar.stall", sb_o_stall_cnt, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    dec(1, 5, 1, 0, 0, 0, 0);
    cycle("ar.rd5", 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
